// File: rtl/wb_sched_pkg.sv
// wb_sched_pkg: shared state encoding, access lengths, store-entry layout and range helper
// for the wb_sched store-buffer scheduler.
package wb_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LD   = 2'd1,
    S_ST   = 2'd2
  } state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
  } st_entry_t;

  // Half-open byte ranges; the 33-bit sums keep a range ending past 2^32 from wrapping.
  function automatic logic ranges_overlap(input logic [31:0] a, input logic [2:0] a_len,
                                          input logic [31:0] b, input logic [2:0] b_len);
    logic [32:0] a_end;
    logic [32:0] b_end;
    a_end = {1'b0, a} + {30'd0, a_len};
    b_end = {1'b0, b} + {30'd0, b_len};
    return ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
  endfunction

endpackage

// File: rtl/wb_overlap_chk.sv
// wb_overlap_chk: checks a load's byte range against every live store-buffer entry and
// selects the youngest overlapping entry for possible forwarding.
module wb_overlap_chk
  import wb_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [DEPTH*32-1:0]      ent_addr,
  input  logic [DEPTH*32-1:0]      ent_data,
  input  logic [DEPTH*3-1:0]       ent_len,
  input  logic [31:0]              ld_addr,
  input  logic [2:0]               ld_len,
  output logic                     hazard,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] overlap;
  logic [DEPTH-1:0] exact;
  logic [31:0]      data_arr [DEPTH];
  logic [AW-1:0]    sel_idx;
  logic [AW-1:0]    idx;
  logic             sel_found;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [AW-1:0] age;
      logic [31:0]   e_addr;
      logic [2:0]    e_len;
      assign e_addr       = ent_addr[gi*32 +: 32];
      assign e_len        = ent_len[gi*3 +: 3];
      assign data_arr[gi] = ent_data[gi*32 +: 32];
      // Age 0 is the head (oldest); only ages below count hold live entries.
      assign age          = AW'(gi) - head;
      assign overlap[gi]  = ({1'b0, age} < count) && ranges_overlap(ld_addr, ld_len, e_addr, e_len);
      assign exact[gi]    = (e_addr == ld_addr) && (e_len == ld_len);
    end
  endgenerate

  // Walk oldest to youngest so the last overlapping entry seen wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = head + AW'(a);
      if (overlap[idx]) begin
        sel_idx   = idx;
        sel_found = 1'b1;
      end
    end
  end

  assign hazard   = |overlap;
  assign fwd_hit  = sel_found && exact[sel_idx];
  assign fwd_data = data_arr[sel_idx];

endmodule

// File: rtl/wb_sched.sv
// wb_sched: in-order store buffer plus load/store issue FSM in front of a memory controller.
// Define WB_SCHED_FWD_EN to answer exact-match loads from the youngest overlapping store.
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_len,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_len,
  output logic        st_ready,
  input  logic        fence_req,
  output logic        fence_done,
  output logic        mc_re,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_w_data,
  output logic [2:0]  mc_len,
  input  logic        mc_busy,
  input  logic        mc_done,
  input  logic [31:0] mc_r_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  st_entry_t     entry_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          mc_re_q, mc_re_d;
  logic          mc_we_q, mc_we_d;
  logic [31:0]   mc_addr_q, mc_addr_d;
  logic [31:0]   mc_w_data_q, mc_w_data_d;
  logic [2:0]    mc_len_q, mc_len_d;
  logic          ld_done_q, ld_done_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          fence_done_q, fence_done_d;
  logic          done_pend_q, done_pend_d;
  logic [31:0]   pend_data_q, pend_data_d;

  logic          push, pop, issue_st, full, load_ok, mc_fin, fwd_ok;
  logic [31:0]   fin_data;
  st_entry_t     head_entry;

  logic [DEPTH*32-1:0] ent_addr_flat;
  logic [DEPTH*32-1:0] ent_data_flat;
  logic [DEPTH*3-1:0]  ent_len_flat;
  logic                hazard, fwd_hit;
  logic [31:0]         fwd_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign ent_addr_flat[gi*32 +: 32] = entry_q[gi].addr;
      assign ent_data_flat[gi*32 +: 32] = entry_q[gi].data;
      assign ent_len_flat[gi*3 +: 3]    = entry_q[gi].len;
    end
  endgenerate

  wb_overlap_chk #(.DEPTH(DEPTH)) u_overlap (
    .head     (head_q),
    .count    (count_q),
    .ent_addr (ent_addr_flat),
    .ent_data (ent_data_flat),
    .ent_len  (ent_len_flat),
    .ld_addr  (ld_addr),
    .ld_len   (ld_len),
    .hazard   (hazard),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

`ifdef WB_SCHED_FWD_EN
  assign fwd_ok = fwd_hit;
`else
  logic fwd_unused;
  assign fwd_ok     = 1'b0;
  assign fwd_unused = fwd_hit;
`endif

  assign full       = (count_q == FULL_CNT);
  assign st_ready   = !full;
  assign head_entry = entry_q[head_q];
  // ld_req stays high through the ld_done cycle; it must not start a second load.
  assign load_ok    = ld_req && !ld_done_q;
  assign mc_fin     = mc_done || done_pend_q;
  assign fin_data   = done_pend_q ? pend_data_q : mc_r_data;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mc_re_d      = mc_re_q;
    mc_we_d      = mc_we_q;
    mc_addr_d    = mc_addr_q;
    mc_w_data_d  = mc_w_data_q;
    mc_len_d     = mc_len_q;
    ld_done_d    = ld_done_q;
    ld_data_d    = ld_data_q;
    fence_done_d = fence_done_q;
    done_pend_d  = done_pend_q;
    pend_data_d  = pend_data_q;
    push         = 1'b0;
    pop          = 1'b0;
    issue_st     = 1'b0;

    if (!rdy_in) begin
      // Everything holds; a completion arriving now is kept for when rdy_in returns.
      if (mc_done && state_q != S_IDLE && !done_pend_q) begin
        done_pend_d = 1'b1;
        pend_data_d = mc_r_data;
      end
    end else begin
      mc_re_d      = 1'b0;
      mc_we_d      = 1'b0;
      ld_done_d    = 1'b0;
      fence_done_d = 1'b0;
      done_pend_d  = 1'b0;
      push         = st_req && !full;

      case (state_q)
        S_IDLE: begin
          if (!mc_busy && count_q != '0 && (full || fence_req)) begin
            issue_st = 1'b1;
          end else if (load_ok && fwd_ok) begin
            ld_done_d = 1'b1;
            ld_data_d = fwd_data;
          end else if (!mc_busy && load_ok && !hazard) begin
            mc_re_d  = 1'b1;
            mc_addr_d = ld_addr;
            mc_len_d = ld_len;
            state_d  = S_LD;
          end else if (!mc_busy && count_q != '0) begin
            issue_st = 1'b1;
          end
        end
        S_LD: begin
          if (mc_fin) begin
            ld_data_d = fin_data;
            ld_done_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_ST: begin
          if (mc_fin) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (issue_st) begin
        mc_we_d     = 1'b1;
        mc_addr_d   = head_entry.addr;
        mc_w_data_d = head_entry.data;
        mc_len_d    = head_entry.len;
        state_d     = S_ST;
      end

      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);

      fence_done_d = fence_req && !fence_done_q && (count_d == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mc_re_q      <= 1'b0;
      mc_we_q      <= 1'b0;
      mc_addr_q    <= '0;
      mc_w_data_q  <= '0;
      mc_len_q     <= '0;
      ld_done_q    <= 1'b0;
      ld_data_q    <= '0;
      fence_done_q <= 1'b0;
      done_pend_q  <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mc_re_q      <= mc_re_d;
      mc_we_q      <= mc_we_d;
      mc_addr_q    <= mc_addr_d;
      mc_w_data_q  <= mc_w_data_d;
      mc_len_q     <= mc_len_d;
      ld_done_q    <= ld_done_d;
      ld_data_q    <= ld_data_d;
      fence_done_q <= fence_done_d;
      done_pend_q  <= done_pend_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Entry storage needs no reset: count and pointers alone define what is live.
  always_ff @(posedge clk_in) begin
    if (push) entry_q[tail_q] <= '{addr: st_addr, data: st_data, len: st_len};
  end

  // Pulses raised while frozen stay in their flops and appear once rdy_in returns.
  assign mc_re      = mc_re_q && rdy_in;
  assign mc_we      = mc_we_q && rdy_in;
  assign ld_done    = ld_done_q && rdy_in;
  assign fence_done = fence_done_q && rdy_in;
  assign mc_addr    = mc_addr_q;
  assign mc_w_data  = mc_w_data_q;
  assign mc_len     = mc_len_q;
  assign ld_data    = ld_data_q;

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed vectors for wb_sched against a fixed-latency controller model.
module tb_wb_sched;

  localparam int MC_LAT = 3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_len = '0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_len = '0;
  logic        fence_req = 1'b0;
  logic        mc_busy = 1'b0;
  logic        mc_done = 1'b0;
  logic [31:0] mc_r_data = '0;
  logic        ld_done, st_ready, fence_done, mc_re, mc_we;
  logic [31:0] ld_data, mc_addr, mc_w_data;
  logic [2:0]  mc_len;

  wb_sched #(.DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_len(st_len),
    .st_ready(st_ready), .fence_req(fence_req), .fence_done(fence_done),
    .mc_re(mc_re), .mc_we(mc_we), .mc_addr(mc_addr), .mc_w_data(mc_w_data),
    .mc_len(mc_len), .mc_busy(mc_busy), .mc_done(mc_done), .mc_r_data(mc_r_data)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ld_done_n = 0;
  int ld_done_cyc = 0;
  int fence_n = 0;
  int fence_cyc = 0;
  logic [31:0] ld_data_seen = '0;
  logic        iss_we_q [$];
  logic [31:0] iss_addr_q [$];
  logic [31:0] mem [logic [31:0]];
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // Controller model plus event log, sampled 1 time unit after each rising edge.
  always @(posedge clk_in) begin
    #1;
    cyc++;
    mc_done = 1'b0;
    if (rst_in) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          mc_done   = 1'b1;
          pend      = 1'b0;
          mc_r_data = mem.exists(pend_addr) ? mem[pend_addr] : 32'hDEADBEEF;
        end else begin
          pend_cnt--;
        end
      end
      if (mc_re || mc_we) begin
        pend      = 1'b1;
        pend_cnt  = MC_LAT - 1;
        pend_addr = mc_addr;
        iss_we_q.push_back(mc_we);
        iss_addr_q.push_back(mc_addr);
        if (mc_we) mem[mc_addr] = mc_w_data;
        $display("[%0d] issue %s addr=%h wdata=%h len=%0d", cyc, mc_we ? "WR" : "RD",
                 mc_addr, mc_w_data, mc_len);
      end
      if (ld_done) begin
        ld_done_n++;
        ld_done_cyc  = cyc;
        ld_data_seen = ld_data;
        $display("[%0d] ld_done data=%h", cyc, ld_data);
      end
      if (fence_done) begin
        fence_n++;
        fence_cyc = cyc;
        $display("[%0d] fence_done", cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int count_rd();
    int n = 0;
    foreach (iss_we_q[i]) if (!iss_we_q[i]) n++;
    return n;
  endfunction

  task automatic clear_log();
    iss_we_q.delete();
    iss_addr_q.delete();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    int i;
    st_req = 1'b1; st_addr = a; st_data = d; st_len = l;
    i = 0;
    while (!st_ready && i < 100) begin
      @(negedge clk_in);
      i++;
    end
    chk("st_accept", 32'(st_ready), 32'd1);
    @(negedge clk_in);
    st_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] l, output int lat);
    int n0, start, i;
    n0 = ld_done_n; start = cyc;
    ld_req = 1'b1; ld_addr = a; ld_len = l;
    i = 0;
    while (ld_done_n == n0 && i < 200) begin
      @(negedge clk_in);
      i++;
    end
    ld_req = 1'b0;
    chk("ld_wait", 32'(ld_done_n != n0), 32'd1);
    lat = ld_done_cyc - start;
  endtask

  task automatic do_fence(output int lat);
    int f0, start, i;
    f0 = fence_n; start = cyc;
    fence_req = 1'b1;
    i = 0;
    while (fence_n == f0 && i < 200) begin
      @(negedge clk_in);
      i++;
    end
    fence_req = 1'b0;
    chk("fence_wait", 32'(fence_n != f0), 32'd1);
    lat = fence_cyc - start;
  endtask

  initial begin
    int lat, f0, n0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_outs", {28'd0, st_ready, mc_re, mc_we, ld_done}, 32'h8);
    chk("rst_fence", 32'(fence_done), 32'd0);
    @(negedge clk_in);

    // Plain load on an empty buffer.
    clear_log();
    do_load(32'h100, 3'd4, lat);
    chk("ld_lat", 32'(lat), 32'd5);
    chk("ld_data", ld_data_seen, 32'hDEADBEEF);
    chk("ld_rd_cnt", 32'(iss_we_q.size()), 32'd1);
    chk("ld_addr", iss_addr_q[0], 32'h100);
    repeat (3) @(negedge clk_in);

    // rdy_in low holds off the load issue.
    clear_log();
    rdy_in = 1'b0;
    n0 = ld_done_n;
    ld_req = 1'b1; ld_addr = 32'h400; ld_len = 3'd4;
    repeat (4) @(negedge clk_in);
    chk("rdy_no_issue", 32'(iss_we_q.size()), 32'd0);
    rdy_in = 1'b1;
    do_load(32'h400, 3'd4, lat);
    chk("rdy_ld_cnt", 32'(ld_done_n - n0), 32'd1);
    repeat (3) @(negedge clk_in);

    // Fill the buffer while the controller is busy, then drain in order.
    mc_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'(i * 4), 32'hA0 + 32'(i), 3'd4);
      chk($sformatf("fill_rdy%0d", i), 32'(st_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    clear_log();
    mc_busy = 1'b0;
    repeat (40) @(negedge clk_in);
    chk("drain_cnt", 32'(iss_we_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < iss_we_q.size(); i++) begin
      chk($sformatf("drain_addr%0d", i), {iss_addr_q[i][30:0], iss_we_q[i]}, {32'(i * 4)} << 1 | 32'd1);
    end
    chk("drain_rdy", 32'(st_ready), 32'd1);

    // Exact-match load behind a buffered store.
    mc_busy = 1'b1;
    do_store(32'h200, 32'h11223344, 3'd4);
    clear_log();
    mc_busy = 1'b0;
    do_load(32'h200, 3'd4, lat);
    chk("fwd_data", ld_data_seen, 32'h11223344);
    repeat (15) @(negedge clk_in);
`ifdef WB_SCHED_FWD_EN
    chk("fwd_lat", 32'(lat), 32'd1);
    chk("fwd_no_rd", 32'(count_rd()), 32'd0);
`else
    chk("haz_order_cnt", 32'(iss_we_q.size()), 32'd2);
    if (iss_we_q.size() >= 2) chk("haz_order", {31'd0, iss_we_q[0]} << 1 | 32'(iss_we_q[1]), 32'h2);
`endif

    // Partial overlap: the store must drain first in either build.
    mc_busy = 1'b1;
    do_store(32'h300, 32'h0000BEEF, 3'd2);
    clear_log();
    mc_busy = 1'b0;
    do_load(32'h301, 3'd1, lat);
    chk("part_cnt", 32'(iss_we_q.size()), 32'd2);
    if (iss_we_q.size() >= 2) begin
      chk("part_first", {iss_addr_q[0][30:0], iss_we_q[0]}, 32'h601);
      chk("part_second", {iss_addr_q[1][30:0], iss_we_q[1]}, 32'h602);
    end
    repeat (3) @(negedge clk_in);

    // Fence drains three buffered stores.
    mc_busy = 1'b1;
    for (int i = 0; i < 3; i++) do_store(32'h700 + 32'(i * 4), 32'h70 + 32'(i), 3'd4);
    clear_log();
    f0 = fence_n;
    mc_busy = 1'b0;
    do_fence(lat);
    chk("fence_wr_cnt", 32'(iss_we_q.size()), 32'd3);
    if (iss_we_q.size() >= 3) chk("fence_last", iss_addr_q[2], 32'h708);
    repeat (3) @(negedge clk_in);
    chk("fence_once", 32'(fence_n - f0), 32'd1);
    do_fence(lat);
    chk("fence_empty_lat", 32'(lat), 32'd1);
    repeat (2) @(negedge clk_in);

    // Reset mid-store with two entries buffered.
    mc_busy = 1'b1;
    do_store(32'h500, 32'h50, 3'd4);
    do_store(32'h504, 32'h54, 3'd4);
    mc_busy = 1'b0;
    repeat (2) @(negedge clk_in);
    n0 = ld_done_n;
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("mid_rst_outs", {28'd0, st_ready, mc_re, mc_we, ld_done}, 32'h8);
    rst_in = 1'b0;
    clear_log();
    mc_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h600 + 32'(i * 4), 32'h60 + 32'(i), 3'd4);
      chk($sformatf("post_rst_rdy%0d", i), 32'(st_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    chk("post_rst_idle", 32'(iss_we_q.size()), 32'd0);
    mc_busy = 1'b0;
    repeat (30) @(negedge clk_in);
    chk("post_rst_cnt", 32'(iss_we_q.size()), 32'd4);
    if (iss_we_q.size() >= 1) chk("post_rst_first", iss_addr_q[0], 32'h600);
    chk("post_rst_no_ld", 32'(ld_done_n - n0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 Parameter DEPTH, default 4, store-buffer entries (power of two, >=2).
REQ-002 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 ld_req  input  1  load request; held high until ld_done.
REQ-006 ld_addr  input  32  load byte address.
REQ-007 ld_len  input  3  load length in bytes (1, 2 or 4).
REQ-008 ld_done  output  1  one-cycle pulse; ld_data valid.
REQ-009 ld_data  output  32  load result, right-aligned.
REQ-010 st_req  input  1  store request.
REQ-011 st_addr / st_data / st_len  input  32/32/3  store address, data and length.
REQ-012 st_ready  output  1  combinational; high when the buffer is not full.
REQ-013 fence_req  input  1  drain request; held high until fence_done.
REQ-014 fence_done  output  1  one-cycle pulse; buffer empty.
REQ-015 mc_re / mc_we  output  1/1  one-cycle issue strobes to the memory controller.
REQ-016 mc_addr / mc_w_data / mc_len  output  32/32/3  issued request fields, registered.
REQ-017 mc_busy / mc_done  input  1/1  controller busy level and completion pulse.
REQ-018 mc_r_data  input  32  controller read data, valid with mc_done.

Function
REQ-019 Buffer:
- A store is accepted on an edge where st_req && st_ready.
- Entries are appended at the tail; head/tail pointers wrap modulo DEPTH.
- An occupancy counter runs 0..DEPTH; st_ready = (count != DEPTH).
REQ-020 FSM states: S_IDLE, S_LD (load issued, awaiting mc_done), S_ST (head store issued, awaiting mc_done).
REQ-021 Issue rules:
- Issue happens only from S_IDLE with mc_busy == 0.
- The chosen strobe is high for exactly one cycle after the deciding edge.
- The state moves to S_LD or S_ST on that same edge.
REQ-022 Priority, in S_IDLE:
1. Head store when the buffer is full, or when fence_req is high and count > 0.
2. A non-hazard load when ld_req is high.
3. Head store when count > 0.
REQ-023 Hazard: a load overlaps a buffered entry when [ld_addr, ld_addr+ld_len) intersects [st_addr, st_addr+st_len); 32-bit wrap is ignored. Overlapping loads are not issued (see REQ-033).
REQ-024 S_LD on mc_done:
- ld_data <= mc_r_data.
- ld_done pulses the next cycle.
- State returns to S_IDLE.
- Load latency is 2 cycles plus the controller latency.
REQ-025 S_ST on mc_done: the head entry is popped and the state returns to S_IDLE.
REQ-026 A store accepted in the same cycle as a pop leaves count unchanged.
REQ-027 fence_done pulses in the cycle after count reaches 0 while fence_req is high. It pulses immediately, one cycle after sampling, if the buffer is already empty.
REQ-028 Ordering: stores drain strictly in program order; loads never reorder past an overlapping older store.
REQ-029 mc_done outside S_LD/S_ST is ignored.
REQ-030 rdy_in low: no capture, no issue and no pulses; a pulse due is delayed, not lost.

Reset
REQ-031 A reset edge forces the following, including mid-operation:
- State S_IDLE; count and pointers 0; buffer contents discarded.
- All outputs 0 except st_ready = 1.
- An in-flight controller access is abandoned; the controller is reset by the same rst_in.

Configuration
REQ-032 With WB_SCHED_FWD_EN defined, a load whose youngest overlapping entry has an exact address and length match is answered without memory access:
- ld_data is that entry's data.
- ld_done pulses one cycle after ld_req is sampled in S_IDLE.
REQ-033 Without WB_SCHED_FWD_EN, and for every partial overlap in either build, a hazard load waits while stores drain, then issues normally.

Structure
REQ-034 The shared package holds:
- state encoding;
- length constants LEN_B = 1, LEN_H = 2, LEN_W = 4;
- the store-entry struct typedef (addr, data, len).
REQ-035 One sub-module, wb_overlap_chk, performs the combinational per-entry range intersect and youngest-match select.

Verification
REQ-036 Empty buffer, ld_req to 0x100 len 4, mc_done after 3 cycles with data 0xDEADBEEF -> mc_re one cycle, ld_done with ld_data 0xDEADBEEF, 5 cycles after request.
REQ-037 Four stores to 0x0/0x4/0x8/0xC while mc_busy = 1 -> st_ready low after the fourth; with mc_busy low, mc_we issued in order 0x0, 0x4, 0x8, 0xC.
REQ-038 Store 0x11223344 to 0x200 len 4 buffered, then load 0x200 len 4 -> with FWD: ld_done in 1 cycle with 0x11223344, no mc_re; without FWD: mc_we precedes mc_re.
REQ-039 Store to 0x300 len 2, then load 0x301 len 1 -> store drains before mc_re in both builds.
REQ-040 Three stores, then fence_req -> three mc_we, then fence_done once count = 0; fence on an empty buffer -> fence_done after 1 cycle.
REQ-041 rst_in asserted while in S_ST with two entries -> next cycle count 0, st_ready 1, no mc_we/mc_re, no stale ld_done.
